// File: rtl/imem_pkg.sv
// imem_pkg: constants, loader state encoding and the word-index to byte-address
// helper shared by the program loader and the instruction RAM (which indexes a[31:2]).
package imem_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // Byte address of a word: {zeros, idx, 2'b00}.
  function automatic logic [31:0] word_addr(input logic [AW-1:0] idx);
    logic [31:0] a;
    a         = '0;
    a[AW+1:2] = idx;
    return a;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian bytes into 32-bit words and keeps a
// running XOR checksum of every byte it accepts.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         restart at lane 0 with a zero checksum
//   i_byte_en       accept i_byte this cycle
//   i_byte          stream byte
//   o_word_done     combinational: the byte accepted this cycle completes a word
//   o_word_valid    registered one-cycle pulse, o_word holds the new word
//   o_word          last completed word (held between pulses)
//   o_csum          XOR of all bytes accepted since the last clear
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [7:0]  o_csum
);

  logic [1:0]  r_lane, w_lane_d;
  logic [23:0] r_shift, w_shift_d;
  logic [31:0] r_word, w_word_d;
  logic        r_word_valid, w_word_valid_d;
  logic [7:0]  r_csum, w_csum_d;

  always_comb begin
    w_lane_d       = r_lane;
    w_shift_d      = r_shift;
    w_word_d       = r_word;
    w_word_valid_d = 1'b0;
    w_csum_d       = r_csum;
    if (i_clear) begin
      w_lane_d = 2'd0;
      w_csum_d = 8'd0;
    end else if (i_byte_en) begin
      w_csum_d = r_csum ^ i_byte;
      w_lane_d = r_lane + 2'd1;
      unique case (r_lane)
        2'd0: w_shift_d[7:0]   = i_byte;
        2'd1: w_shift_d[15:8]  = i_byte;
        2'd2: w_shift_d[23:16] = i_byte;
        2'd3: begin
          w_word_d       = {i_byte, r_shift};
          w_word_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane       <= 2'd0;
      r_shift      <= 24'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
      r_csum       <= 8'd0;
    end else begin
      r_lane       <= w_lane_d;
      r_shift      <= w_shift_d;
      r_word       <= w_word_d;
      r_word_valid <= w_word_valid_d;
      r_csum       <= w_csum_d;
    end
  end

  assign o_word_done  = i_byte_en && !i_clear && (r_lane == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;
  assign o_csum       = r_csum;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (count N, 4*N little-endian
// instruction bytes, XOR checksum) and writes the words into the instruction
// RAM through its synchronous write port, holding the CPU in reset meanwhile.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              pulse: begin a load (clears done/err when finished)
//   i_rx_data/i_rx_valid stream byte and its valid; o_rx_ready is the handshake
//   o_mem_we/wa/wd       RAM write port: one-cycle pulse, byte address, word
//   o_cpu_hold           processor reset request
//   o_busy               load in progress
//   o_done, o_err        sticky completion / failure flags
module imem_loader
  import imem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wa,
  output logic [31:0] o_mem_wd,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  loader_state_t r_state, w_state_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic [AW-1:0] r_last, w_last_d;
  logic          r_chk_got, w_chk_got_d;
  logic          r_chk_ok, w_chk_ok_d;
  logic [31:0]   r_wa, w_wa_d;
  logic          r_rx_ready, w_rx_ready_d;
  logic          r_cpu_hold, w_cpu_hold_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic          r_err, w_err_d;

  logic          w_accept;
  logic          w_pack_clear;
  logic          w_pack_en;
  logic          w_word_done;
  logic          w_word_valid;
  logic [31:0]   w_word;
  logic [7:0]    w_csum;
  logic [7:0]    w_n_m1;

  assign w_accept = i_rx_valid && r_rx_ready;
  // N in 1..DEPTH maps to a last index in 0..DEPTH-1; DEPTH itself wraps to all ones.
  assign w_n_m1   = i_rx_data - 8'd1;

  imem_word_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_pack_clear),
    .i_byte_en    (w_pack_en),
    .i_byte       (i_rx_data),
    .o_word_done  (w_word_done),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_csum       (w_csum)
  );

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_last_d     = r_last;
    w_chk_got_d  = r_chk_got;
    w_chk_ok_d   = r_chk_ok;
    w_wa_d       = r_wa;
    w_done_d     = r_done;
    w_err_d      = r_err;
    w_pack_clear = 1'b0;
    w_pack_en    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_d = COUNT;
      end
      COUNT: begin
        if (w_accept) begin
          if (i_rx_data != 8'd0 && i_rx_data <= 8'(DEPTH)) begin
            w_state_d    = DATA;
            w_idx_d      = '0;
            w_last_d     = w_n_m1[AW-1:0];
            w_pack_clear = 1'b1;
          end else begin
            w_state_d = ERR;
            w_err_d   = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          w_pack_en = 1'b1;
          if (w_word_done) begin
            w_wa_d = word_addr(r_idx);
            if (r_idx == r_last) begin
              w_state_d   = CHECK;
              w_chk_got_d = 1'b0;
            end else begin
              w_idx_d = r_idx + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
      end
      CHECK: begin
        // Capture the checksum byte first, resolve on the following cycle.
        if (!r_chk_got) begin
          if (w_accept) begin
            w_chk_got_d = 1'b1;
            w_chk_ok_d  = (i_rx_data == w_csum);
          end
        end else if (r_chk_ok) begin
          w_state_d = DONE;
          w_done_d  = 1'b1;
        end else begin
          w_state_d = ERR;
          w_err_d   = 1'b1;
        end
      end
      DONE, ERR: begin
        if (i_start) begin
          w_state_d = COUNT;
          w_done_d  = 1'b0;
          w_err_d   = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase

    w_rx_ready_d = (w_state_d == COUNT) || (w_state_d == DATA) ||
                   ((w_state_d == CHECK) && !w_chk_got_d);
    w_busy_d     = (w_state_d == COUNT) || (w_state_d == DATA) || (w_state_d == CHECK);
    w_cpu_hold_d = (w_state_d != IDLE) && (w_state_d != DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_last     <= '0;
      r_chk_got  <= 1'b0;
      r_chk_ok   <= 1'b0;
      r_wa       <= 32'd0;
      r_rx_ready <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_last     <= w_last_d;
      r_chk_got  <= w_chk_got_d;
      r_chk_ok   <= w_chk_ok_d;
      r_wa       <= w_wa_d;
      r_rx_ready <= w_rx_ready_d;
      r_cpu_hold <= w_cpu_hold_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_mem_we   = w_word_valid;
  assign o_mem_wa   = r_wa;
  assign o_mem_wd   = w_word;
  assign o_cpu_hold = r_cpu_hold;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_mem_we   (mem_we),
    .o_mem_wa   (mem_wa),
    .o_mem_wd   (mem_wd),
    .o_cpu_hold (cpu_hold),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         spec_words;
    logic [7:0] xr;        // XORed into the correct checksum to corrupt it
    bit         gap;
    bit         mid_start;
    bit         exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
  } wr_t;

  int          checks;
  int          failures;
  int          we_count;
  wr_t         exp_q[$];
  logic [31:0] wbuf[64];
  vec_t        vecs[6];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Write scoreboard.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h@%h required=none", mem_wd, mem_wa);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mem_wa", mem_wa, e.wa);
        chk("mem_wd", mem_wd, e.wd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout actual=not_accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic fill_words(input vec_t v);
    if (v.spec_words) begin
      wbuf[0] = 32'hE3A00004;
      wbuf[1] = 32'hE3A01008;
    end else begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom();
    end
  endtask

  task automatic do_load(input vec_t v);
    logic [7:0] cs;
    logic [7:0] b;
    wr_t        e;
    fill_words(v);
    we_count = 0;
    cs       = 8'd0;
    pulse_start();
    chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_clears_done", {31'd0, done}, 32'd0);
    chk("start_clears_err", {31'd0, err}, 32'd0);
    send_byte(8'(v.n));
    for (int i = 0; i < v.n; i++) begin
      e.wa = 32'(i) << 2;
      e.wd = wbuf[i];
      exp_q.push_back(e);
      for (int l = 0; l < 4; l++) begin
        b  = wbuf[i][8*l +: 8];
        cs = cs ^ b;
        if (v.mid_start && i == 0 && l == 2) start = 1'b1;
        send_byte(b);
        start = 1'b0;
        if (v.gap) begin
          @(posedge clk); #1;
        end
      end
    end
    send_byte(cs ^ v.xr);
    chk("flag_not_early", {30'd0, done, err}, 32'd0);
    @(posedge clk); #1;
    chk("end_done", {31'd0, done}, {31'd0, v.exp_done});
    chk("end_err", {31'd0, err}, {31'd0, !v.exp_done});
    chk("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !v.exp_done});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("we_count", 32'(we_count), 32'(v.n));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_wa"}, mem_wa, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    we_count = 0;
    start    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    rst_n    = 1'b0;

    //           n   spec  xr     gap  mid  done
    vecs[0] = '{2,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1};  // checksum 0x1C
    vecs[1] = '{2,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0};  // checksum 0x1D
    vecs[2] = '{64, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1,  1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    #23;
    chk_reset_values("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Bytes offered while idle must not be consumed.
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    rx_valid = 1'b0;

    for (int k = 0; k < 6; k++) do_load(vecs[k]);

    // Invalid counts: 0 and DEPTH+1.
    we_count = 0;
    pulse_start();
    send_byte(8'h00);
    chk("n0_err", {31'd0, err}, 32'd1);
    chk("n0_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("n0_busy", {31'd0, busy}, 32'd0);
    chk("n0_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("n0_done", {31'd0, done}, 32'd0);
    pulse_start();
    chk("restart_err_cleared", {31'd0, err}, 32'd0);
    chk("restart_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h41);
    chk("n41_err", {31'd0, err}, 32'd1);
    chk("n41_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_count_no_writes", 32'(we_count), 32'd0);

    // Reset mid-load after 5 data bytes of a 2-word frame.
    fill_words(vecs[0]);
    we_count = 0;
    pulse_start();
    send_byte(8'h02);
    begin
      wr_t e;
      e.wa = 32'h0;
      e.wd = wbuf[0];
      exp_q.push_back(e);
    end
    for (int j = 0; j < 5; j++) send_byte(wbuf[j / 4][8*(j % 4) +: 8]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_writes", 32'(we_count), 32'd1);
    chk("midrst_q", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory of the ARM single-cycle processor at run time instead of relying on the image preloaded at build time. It accepts a framed byte stream (word count, little-endian instruction bytes, XOR checksum), assembles 32-bit words and drives a word-aligned write port into the 64-word instruction RAM. While loading, it holds the processor in reset.

## Interface
- DEPTH, 64, number of 32-bit words in instruction memory
- AW, 6, word-index width, equal to clog2(DEPTH)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid and rx_ready are both high on a rising edge
- mem_we  out  1  instruction RAM write enable, one-cycle pulse per word
- mem_wa  out  32  byte address of the word, {24'b0, idx[AW-1:0], 2'b00}
- mem_wd  out  32  assembled instruction word
- cpu_hold  out  1  processor reset request
- busy  out  1  load in progress
- done  out  1  sticky; load completed and checksum matched
- err  out  1  sticky; bad count or checksum mismatch

## Operation
- States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
- IDLE: on start → COUNT; start is ignored in COUNT, DATA and CHECK; in DONE and ERR, start clears done/err → COUNT.
- COUNT: accepts one byte N. If 1 ≤ N ≤ DEPTH → DATA, word index idx=0, byte lane=0, checksum=0. Otherwise (0 or >DEPTH) → ERR.
- DATA: accepts 4·N bytes, little-endian: lane 0 → wd[7:0] … lane 3 → wd[31:24]. Each accepted byte XORs into the checksum. On lane 3 accept, the word is complete. After the word with idx=N-1 completes → CHECK.
- CHECK: accepts one byte. If it equals the checksum → DONE, else → ERR. Words already written remain in RAM in either case.
- rx_ready=1 only in COUNT, DATA and CHECK; 0 elsewhere. Bytes with rx_valid=1 while rx_ready=0 are not consumed.
- cpu_hold=1 in COUNT, DATA, CHECK and ERR; 0 in IDLE and DONE. A failed load keeps the CPU held.
- busy=1 in COUNT, DATA and CHECK.
- The index never wraps: N ≤ DEPTH bounds idx to DEPTH-1.
- Reset asserted mid-load aborts immediately. Partial RAM contents are left as written; no further writes occur.

## Timing
- All outputs are registered. Reset values: state IDLE, rx_ready=0, mem_we=0, mem_wa=0, mem_wd=0, cpu_hold=0, busy=0, done=0, err=0.
- start at edge k → state COUNT and rx_ready=1, visible after edge k; cpu_hold=1 from the same edge.
- Sustains 1 byte/cycle with rx_valid held high.
- Lane-3 byte accepted at edge k → mem_we=1 with valid mem_wa/mem_wd for exactly the cycle after edge k; deasserted after edge k+1.
- mem_wa/mem_wd hold their last values while mem_we=0.
- Last data byte at edge k, checksum byte at edge k+1 (earliest) → done/err set after edge k+2. cpu_hold drops on that same edge when done.
- A total of N·4+2 byte transfers per load (count + data + checksum).

## Structure
- Shared package imem_pkg: DEPTH and AW constants, loader_state_t enum {IDLE, COUNT, DATA, CHECK, DONE, ERR}, and the word-to-byte-address helper also used by the RAM's a[31:2] indexing.
- One natural sub-module: imem_word_packer (byte lane counter, little-endian shift-in, XOR checksum, word_valid pulse). The FSM and address counter stay in imem_loader.
- The instruction RAM gains a synchronous write port (we, wa, wd) driven by this block; the asynchronous read port is unchanged.

## Test plan
- Normal load: start, N=2, bytes 04 00 A0 E3 | 08 10 A0 E3, checksum 0x04^0xA0^0xE3^0x08^0x10^0xA0^0xE3 = 0x1C → writes 0xE3A00004@0x00 and 0xE3A01008@0x04, done=1, cpu_hold=0.
- Bad checksum: same frame with checksum 0x1D → both words written, err=1, done=0, cpu_hold stays 1.
- Invalid count: N=0x00, then N=0x41 (after start) → ERR immediately each time, no mem_we pulse, rx_ready=0.
- Full memory: N=64 (0x40), 256 bytes with back-to-back rx_valid → 64 mem_we pulses, last at mem_wa=0xFC, done asserts 2 cycles after the final data byte.
- Flow control and ignored start: rx_valid toggling every other cycle, start pulsed during DATA → same written words as the gap-free case, state unaffected by start.
- Reset mid-load: assert reset after 5 data bytes of N=2 → all outputs return to reset values asynchronously, only the word at 0x00 was written, a subsequent start performs a clean load.
